// File: rtl/demux_defs_pkg.sv
// Shared definitions for the 1:4 time-division demultiplexer.
package demux_defs_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  // Round-robin alignment state: HUNT discards beats until a frame start,
  // LOCK rotates through the lanes.
  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } demux_state_e;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/demux_lane_reg.sv
// One valid/ready register stage for a single output lane.
// Handshake: a beat transfers on any rising edge where valid & ready are both 1;
// the producer side (load) is only asserted by the parent when the stage is empty
// or draining in the same cycle, so a held beat is never overwritten.
module demux_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: a load wins over a drain, so drain+refill keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Lane register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_1x4_tdm.sv
// 1:4 time-division demultiplexer with addressed and frame-aligned round-robin
// routing. Handshake: the input beat transfers when in_valid & in_ready; each
// lane k transfers when out_valid[k] & out_ready[k]. in_ready depends
// combinationally on out_ready of the target lane.
module demux_1x4_tdm
  import demux_defs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_sel,
  input  logic                       in_sof,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [1:0]                 rr_ptr,
  output logic                       sync_err,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       dbg_state
);

  demux_state_e       state_q, state_d, cur_state;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d, cur_ptr;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               sync_err_q, sync_err_d;
  logic               mode_q, mode_d;

  logic               mode_change;
  logic               hunt_drop;
  logic [SEL_W-1:0]   tgt;
  logic               accept;
  logic [NUM_LANES-1:0] lane_load;

  // Lane-select decode and accept rule. A mode change is seen as an immediate
  // return to HUNT with pointer 0, so the change-cycle beat follows the new mode.
  always_comb begin
    mode_change = (mode != mode_q);
    cur_state   = mode_change ? HUNT : state_q;
    cur_ptr     = mode_change ? '0 : rr_ptr_q;
    hunt_drop   = (mode == MODE_RR) && (cur_state == HUNT) && !in_sof;
    if (mode == MODE_ADDR) begin
      tgt = in_sel;
    end else if ((cur_state == HUNT) || in_sof) begin
      tgt = '0;
    end else begin
      tgt = cur_ptr;
    end
    in_ready  = hunt_drop | ~out_valid[tgt] | out_ready[tgt];
    accept    = in_valid & in_ready;
    lane_load = '0;
    if (accept && !hunt_drop) begin
      lane_load[tgt] = 1'b1;
    end
  end

  // Round-robin FSM next state, pointer, drop counter and sync error.
  always_comb begin
    state_d    = cur_state;
    rr_ptr_d   = cur_ptr;
    drop_cnt_d = drop_cnt_q;
    sync_err_d = 1'b0;
    mode_d     = mode;
    if ((mode == MODE_RR) && accept) begin
      case (cur_state)
        HUNT: begin
          if (in_sof) begin
            rr_ptr_d = 2'd1;
            state_d  = LOCK;
          end else if (!(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        LOCK: begin
          if (in_sof) begin
            // Frame start always realigns to lane 0; flag it if unexpected.
            rr_ptr_d   = 2'd1;
            sync_err_d = (cur_ptr != '0);
          end else begin
            rr_ptr_d = cur_ptr + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      sync_err_q <= 1'b0;
      mode_q     <= MODE_ADDR;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      sync_err_q <= sync_err_d;
      mode_q     <= mode_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (lane_load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign rr_ptr    = rr_ptr_q;
  assign sync_err  = sync_err_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: doc/demux_1x4_tdm.md
Name: demux_1x4_tdm

Overview:
- Time-division demultiplexer, the distributing counterpart of the 4:1 multiplexer path: one input sample stream is routed to one of four registered output lanes.
- Two routing modes:
  - Addressed: the lane is taken from the select input.
  - Round-robin: the lane rotates 0,1,2,3, and the rotation is aligned to a start-of-frame marker.
- Valid/ready handshake on the input and on every lane, so each lane applies backpressure independently.
- Sits between a serialised sample source and four parallel consumers.

Parameters:
- WIDTH, 8, sample data width in bits.
- CNT_W, 16, width of the dropped-beat counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = addressed (lane = in_sel), 1 = round-robin; quasi-static.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid=1.
- in_data  input  WIDTH  input sample.
- in_sel  input  2  target lane in addressed mode; ignored in round-robin mode.
- in_sof  input  1  start of frame, qualified by in_valid; used in round-robin mode only.
- out_valid  output  4  per-lane valid; bit k belongs to lane k.
- out_ready  input  4  per-lane ready.
- out_data  output  4*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- rr_ptr  output  2  next round-robin lane.
- sync_err  output  1  one-cycle pulse on a misaligned in_sof.
- drop_cnt  output  CNT_W  count of beats discarded while hunting; saturates at all-ones.

Behaviour:
- Reset (async, rst=1) forces:
  - out_valid=0, out_data=0, rr_ptr=0, sync_err=0, drop_cnt=0.
  - FSM state = HUNT.
- Lane register: one entry per lane.
  - Accepted beat: lands in the target lane register on the next edge, so out_valid rises one cycle after acceptance.
  - Drain: a lane empties when out_valid[k] & out_ready[k] = 1.
  - Drain and refill of the same lane in the same cycle: the new data is loaded and out_valid stays 1.
- Accept rule, target lane t: in_ready = ~out_valid[t] | out_ready[t]. This is combinational from out_ready.
- Addressed mode (mode=0):
  - t = in_sel. The FSM and rr_ptr are held; in_sof is ignored.
- Round-robin mode (mode=1) FSM:
  - HUNT:
    - in_ready=1 unconditionally for beats with in_sof=0. These beats are discarded and drop_cnt increments (saturating at all-ones).
    - A beat with in_sof=1 targets lane 0 and uses the normal accept rule.
    - On acceptance of that beat: rr_ptr <= 1, state <= LOCK.
  - LOCK:
    - t = rr_ptr. On acceptance rr_ptr increments and wraps 3 -> 0.
    - in_sof=1 with rr_ptr=0 is a normal frame start.
    - in_sof=1 with rr_ptr!=0 is a misalignment. The beat goes to lane 0, rr_ptr <= 1, and sync_err pulses on the cycle after acceptance. State stays LOCK.
- Stalled beats (in_valid & ~in_ready): in_data, in_sel and in_sof must be held stable by the source. No state changes; sync_err is not raised until acceptance.
- Any change of mode, detected by comparing against a registered copy:
  - State <= HUNT, rr_ptr <= 0.
  - Lane contents are kept and drain normally.
  - The input beat in the change cycle is routed using the new mode's rules.
- rst asserted mid-transfer: lane data in flight is lost; no partial handshakes survive.
- No data is ever overwritten while out_valid=1 and out_ready=0.

Decomposition:
- Shared package/include (demux_defs):
  - lane count 4 and lane select width 2.
  - FSM state encodings HUNT=1'b0, LOCK=1'b1.
  - mode encodings MODE_ADDR=0, MODE_RR=1.
- Sub-module demux_lane_reg: one WIDTH-wide valid/ready register stage. It holds load/drain/simultaneous-refill logic and is instantiated 4 times.
- Top level holds the FSM, rr_ptr, drop_cnt and the lane-select decode.

Test Plan:
- Reset mid-stream: assert rst with all lanes full -> out_valid=4'b0000, out_data=0, rr_ptr=0, drop_cnt=0 immediately (async), with no clk edge.
- Addressed mode, out_ready=4'hF: send 0xA0..0xA3 with in_sel=3,1,0,2 -> lane3=0xA0, lane1=0xA1, lane0=0xA2, lane2=0xA3, each valid exactly one cycle after its accept.
- Backpressure: mode=0, out_ready[2]=0:
  - Send two beats to lane 2 -> first held, in_ready=0 on the second.
  - Raise out_ready[2] -> second beat accepted in that same cycle, and lane 2 shows 0x02 the next cycle with no gap in out_valid[2].
- Hunt and lock: mode=1:
  - 3 beats without sof, then sof beat 0x10 followed by 0x11..0x17 -> drop_cnt=3.
  - Lanes receive 0x10/0x14 (lane0), 0x11/0x15 (lane1), 0x12/0x16 (lane2), 0x13/0x17 (lane3).
  - rr_ptr wraps 3 -> 0.
- Misalignment: in LOCK with rr_ptr=2, send 0x55 with in_sof=1 -> 0x55 on lane 0, rr_ptr=1, single-cycle sync_err=1.
- Mode toggle: in LOCK flip mode 1 -> 0 -> 1:
  - State returns to HUNT, rr_ptr=0.
  - The following non-sof beat is dropped (drop_cnt+1).
  - Pending lane data still drains intact.
